// File: rtl/fact_accel_pkg.sv
// Shared types and constants for the fact_accel factorial accelerator.
package fact_accel_pkg;

    typedef enum logic [1:0] {
        FA_FN     = 2'd0,
        FA_CTRL   = 2'd1,
        FA_STATUS = 2'd2,
        FA_RESULT = 2'd3
    } fa_addr_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } fa_state_e;

    localparam int STAT_DONE = 0;
    localparam int STAT_ERR  = 1;
    localparam int STAT_BUSY = 2;

    localparam int FA_MAX_N_DEFAULT = 12;

endpackage

// File: rtl/fact_accel_dp.sv
// Factorial datapath: running product, down-counter and captured RESULT register.
module fact_accel_dp (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    input  logic        capture,
    input  logic        clear,
    input  logic [3:0]  n,
    output logic        cnt_le1,
    output logic [31:0] result
);

    logic [31:0] prod;
    logic [3:0]  cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prod <= 32'd0;
            cnt  <= 4'd0;
        end else if (load) begin
            prod <= 32'd1;
            cnt  <= n;
        end else if (step) begin
            // 32x4 product truncated to 32 bits; 12! still fits.
            prod <= prod * {28'd0, cnt};
            cnt  <= cnt - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result <= 32'd0;
        end else if (clear) begin
            result <= 32'd0;
        end else if (capture) begin
            result <= prod;
        end
    end

    assign cnt_le1 = (cnt <= 4'd1);

endmodule

// File: rtl/fact_accel.sv
// Memory-mapped iterative factorial accelerator: FSM, register file and read mux.
// Optional interrupt output is enabled by defining FACT_ACCEL_IRQ_EN.
module fact_accel
    import fact_accel_pkg::*;
#(
    parameter int MAX_N = FA_MAX_N_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs,
    input  logic        we,
    input  logic [1:0]  a,
    input  logic [31:0] wd,
    output logic [31:0] rd,
`ifdef FACT_ACCEL_IRQ_EN
    output logic        irq,
`endif
    output fa_state_e   fsm_state
);

    // Bus handshake: a write is a single-cycle strobe, taken on the rising
    // edge whenever cs & we are high; reads are combinational with no side effects.

    fa_state_e   state, state_next;
    fa_addr_e    addr;
    logic [3:0]  fn_q;
    logic        done_q, err_q, ie_q;
    logic        wr, go_req, busy, n_bad;
    logic        load, step, capture, clear;
    logic        set_done, set_err, clr_flags;
    logic        cnt_le1;
    logic [31:0] result;
    logic        unused_wd;

    assign addr      = fa_addr_e'(a);
    assign wr        = cs & we;
    assign busy      = (state == ST_CALC);
    assign go_req    = wr && (addr == FA_CTRL) && wd[0];
    assign n_bad     = (int'(fn_q) > MAX_N);
    assign fsm_state = state;
    assign unused_wd = ^wd[31:1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        capture    = 1'b0;
        clear      = 1'b0;
        set_done   = 1'b0;
        set_err    = 1'b0;
        clr_flags  = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (go_req) begin
                    clr_flags = 1'b1;
                    load      = 1'b1;
                    if (n_bad) begin
                        state_next = ST_DONE;
                        set_done   = 1'b1;
                        set_err    = 1'b1;
                        clear      = 1'b1;
                    end else begin
                        state_next = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                if (cnt_le1) begin
                    capture    = 1'b1;
                    set_done   = 1'b1;
                    state_next = ST_DONE;
                end else begin
                    step = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Sets take priority so a rejected GO leaves done and err both high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            if (clr_flags) begin
                done_q <= 1'b0;
                err_q  <= 1'b0;
            end
            if (set_done) done_q <= 1'b1;
            if (set_err)  err_q  <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fn_q <= 4'd0;
        end else if (wr && (addr == FA_FN) && !busy) begin
            fn_q <= wd[3:0];
        end
    end

`ifdef FACT_ACCEL_IRQ_EN
    // ie stays writable while busy; only go is blocked.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ie_q <= 1'b0;
        end else if (wr && (addr == FA_CTRL)) begin
            ie_q <= wd[1];
        end
    end
    assign irq = done_q & ie_q;
`else
    assign ie_q = 1'b0;
`endif

    fact_accel_dp u_dp (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .step    (step),
        .capture (capture),
        .clear   (clear),
        .n       (fn_q),
        .cnt_le1 (cnt_le1),
        .result  (result)
    );

    always_comb begin
        rd = 32'd0;
        case (addr)
            FA_FN:     rd = {28'd0, fn_q};
            FA_CTRL:   rd = {30'd0, ie_q, 1'b0};
            FA_STATUS: begin
                rd[STAT_DONE] = done_q;
                rd[STAT_ERR]  = err_q;
                rd[STAT_BUSY] = busy;
            end
            FA_RESULT: rd = result;
            default:   rd = 32'd0;
        endcase
    end

endmodule
